alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
ID/EX stage directly upstream of the ALU. Accepts one fetched instruction plus register-file operands per handshake. Decodes the group's RV32I subset into ALU operands and a 3-bit ALU control code (0 ADD, 1 SUB, 2 XOR, 3 SLL, 4 BNE). Holds the result in a single-entry valid/ready pipeline register, with flush, that drives the ALU and the downstream EX/MEM logic.

Parameters:
XLEN, 32, datapath width of PC, operands and immediates
CTRL_W, 3, width of ALU control code

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept this cycle
instr  input  32  raw instruction word
pc  input  XLEN  PC of instr
rs1_data  input  XLEN  register-file read port 1
rs2_data  input  XLEN  register-file read port 2
flush  input  1  kill held entry and any incoming one
out_valid  output  1  entry held for ALU
out_ready  input  1  downstream consumes entry
alu_a  output  XLEN  ALU operand A
alu_b  output  XLEN  ALU operand B
alu_ctrl  output  CTRL_W  ALU operation code
store_data  output  XLEN  rs2_data for stores
rd  output  5  destination register
reg_write  output  1  writeback enable
mem_read  output  1  load
mem_write  output  1  store
branch  output  1  BNE; taken if ALU Y nonzero
branch_target  output  XLEN  pc + imm_B, modulo 2^XLEN
pc_out  output  XLEN  PC of held entry
illegal  output  1  unsupported encoding

Behaviour:
- Reset (rst_n low, async): every registered output is 0, out_valid=0. Reset asserted mid-transfer drops the entry. in_ready is combinational and reads 1 after reset.
- in_ready = !out_valid || out_ready. It is independent of flush and in_valid.
- Capture on a rising edge when in_valid && in_ready && !flush. Outputs reflect the instruction one cycle later (latency 1). out_valid stays set until out_ready or flush.
- Pass-through: with out_valid=1 and out_ready=1, the stage accepts a new entry in the same cycle. The result is back-to-back throughput of 1 per cycle.
- Hold: with out_valid=1 and out_ready=0, all outputs stay stable and the stage does not capture.
- out_valid=0 with out_ready=1: no effect.
- flush at an edge: out_valid goes 0. A concurrent in_valid is dropped, because flush wins. Data outputs may keep stale values, but every enable (reg_write, mem_read, mem_write, branch, illegal) is cleared.
- Decode (the `opcode/funct3/funct7` columns are the match conditions; the remaining fields are the registered outputs):
  - R 0110011, f3 000, f7 0000000: ADD, a=rs1, b=rs2, reg_write.
  - R 0110011, f3 000, f7 0100000: SUB, a=rs1, b=rs2, reg_write.
  - R 0110011, f3 100, f7 0: XOR, a=rs1, b=rs2, reg_write.
  - R 0110011, f3 001, f7 0: SLL, a=rs1, b=rs2, reg_write.
  - I 0010011, f3 000: ADD, a=rs1, b=imm_I, reg_write.
  - lw 0000011, f3 010: ADD, a=rs1, b=imm_I, mem_read, reg_write.
  - sw 0100011, f3 010: ADD, a=rs1, b=imm_S, mem_write, store_data=rs2, rd=0.
  - bne 1100011, f3 001: ctrl 4, a=rs1, b=rs2, branch, rd=0.
  - Anything else: illegal=1, all enables 0, ctrl 0, a=b=0.
- Immediates are sign-extended from bit 31. imm_B has bit0=0.
- rd=0 forces reg_write=0.
- out_valid=0 means every enable is ignored downstream.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, alu_ctrl=0, reg_write=0 immediately (no clock edge); in_ready=1.
- add/sub: instr 0x002081B3, rs1=7, rs2=5 -> next cycle alu_a=7, alu_b=5, ctrl=0, rd=3, reg_write=1. Then back-to-back 0x402081B3 -> ctrl=1, with out_valid held high both cycles (out_ready=1).
- lw/sw: 0xFFC0A283, rs1=0x100 -> alu_b=0xFFFFFFFC, ctrl=0, mem_read=1, rd=5. Then 0x0020A623, rs2=0xAB -> alu_b=12, mem_write=1, store_data=0xAB, reg_write=0.
- bne: 0x00209463, pc=0x40, rs1=3, rs2=3 -> ctrl=4, branch=1, branch_target=0x48, reg_write=0.
- Backpressure/flush: out_ready=0 for 3 cycles -> outputs stable, in_ready=0, new instr not captured. Then flush=1 with in_valid=1 -> out_valid=0 next cycle, incoming dropped.
- Illegal/x0: instr 0x00000000 -> illegal=1, all enables 0. add x0: 0x00208033 -> reg_write=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue_stage: RV32I-subset decode into a valid/ready register  |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   store_data,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic [XLEN-1:0]   branch_target,
  output logic [XLEN-1:0]   pc_out,
  output logic              illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] CTRL_SUB = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] CTRL_XOR = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] CTRL_SLL = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] CTRL_BNE = CTRL_W'(4);

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [4:0]        w_rd_f;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_s;
  logic [XLEN-1:0]   w_imm_b;
  logic              w_unused;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_rd_f   = instr[11:7];
  assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  // rs1 field is consumed by the register file, not by this stage
  assign w_unused = ^instr[19:15];

  logic [CTRL_W-1:0] w_ctrl;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [XLEN-1:0]   w_sd;
  logic [4:0]        w_rd;
  logic              w_legal;
  logic              w_writes;
  logic              w_mr;
  logic              w_mw;
  logic              w_br;

  always_comb begin
    w_ctrl   = CTRL_ADD;
    w_a      = rs1_data;
    w_b      = rs2_data;
    w_sd     = '0;
    w_rd     = w_rd_f;
    w_legal  = 1'b1;
    w_writes = 1'b0;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    w_br     = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_writes = 1'b1;
        if (w_f3 == 3'b000 && w_f7 == 7'b0000000)      w_ctrl = CTRL_ADD;
        else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) w_ctrl = CTRL_SUB;
        else if (w_f3 == 3'b100 && w_f7 == 7'b0000000) w_ctrl = CTRL_XOR;
        else if (w_f3 == 3'b001 && w_f7 == 7'b0000000) w_ctrl = CTRL_SLL;
        else                                           w_legal = 1'b0;
      end
      OP_I: begin
        w_b      = w_imm_i;
        w_writes = 1'b1;
        w_legal  = (w_f3 == 3'b000);
      end
      OP_LOAD: begin
        w_b      = w_imm_i;
        w_writes = 1'b1;
        w_mr     = 1'b1;
        w_legal  = (w_f3 == 3'b010);
      end
      OP_STORE: begin
        w_b     = w_imm_s;
        w_mw    = 1'b1;
        w_sd    = rs2_data;
        w_rd    = 5'd0;
        w_legal = (w_f3 == 3'b010);
      end
      OP_BR: begin
        w_ctrl  = CTRL_BNE;
        w_br    = 1'b1;
        w_rd    = 5'd0;
        w_legal = (w_f3 == 3'b001);
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_ctrl   = CTRL_ADD;
      w_a      = '0;
      w_b      = '0;
      w_sd     = '0;
      w_rd     = 5'd0;
      w_writes = 1'b0;
      w_mr     = 1'b0;
      w_mw     = 1'b0;
      w_br     = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctrl      <= '0;
      store_data    <= '0;
      rd            <= '0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch        <= 1'b0;
      branch_target <= '0;
      pc_out        <= '0;
      illegal       <= 1'b0;
    end else if (flush) begin
      // data fields may go stale; only the qualifiers must die
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      illegal   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_a         <= w_a;
        alu_b         <= w_b;
        alu_ctrl      <= w_ctrl;
        store_data    <= w_sd;
        rd            <= w_rd;
        reg_write     <= w_writes && (w_rd != 5'd0);
        mem_read      <= w_mr;
        mem_write     <= w_mw;
        branch        <= w_br;
        branch_target <= pc + w_imm_b;
        pc_out        <= pc;
        illegal       <= !w_legal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_issue_stage: directed + random bench with reference model  |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_a, alu_b, store_data, branch_target, pc_out;
  logic [2:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, branch, illegal;

  alu_issue_stage #(.XLEN(32), .CTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .branch_target(branch_target), .pc_out(pc_out),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a, b, sd, bt, pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, ill;
  } ent_t;

  ent_t m_ent;
  bit   m_valid;

  function automatic ent_t model_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
    ent_t e;
    int   imm_i, imm_s, imm_b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit   wr;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    imm_i = $signed(i) >>> 20;
    imm_s = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
    imm_b = {i[7], i[30:25], i[11:8], 1'b0};
    if (i[31]) imm_b = imm_b - 4096;
    e = '{ctrl: 3'd0, a: 32'd0, b: 32'd0, sd: 32'd0, bt: 32'd0, pc: 32'd0,
          rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b0};
    e.pc = p;
    e.bt = p + imm_b;
    e.rd = i[11:7];
    wr = 1'b0;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00)      begin e.ctrl = 3'd0; e.a = r1; e.b = r2; wr = 1; end
    else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin e.ctrl = 3'd1; e.a = r1; e.b = r2; wr = 1; end
    else if (op == 7'h33 && f3 == 3'd4 && f7 == 7'h00) begin e.ctrl = 3'd2; e.a = r1; e.b = r2; wr = 1; end
    else if (op == 7'h33 && f3 == 3'd1 && f7 == 7'h00) begin e.ctrl = 3'd3; e.a = r1; e.b = r2; wr = 1; end
    else if (op == 7'h13 && f3 == 3'd0) begin e.a = r1; e.b = imm_i; wr = 1; end
    else if (op == 7'h03 && f3 == 3'd2) begin e.a = r1; e.b = imm_i; wr = 1; e.mr = 1; end
    else if (op == 7'h23 && f3 == 3'd2) begin e.a = r1; e.b = imm_s; e.mw = 1; e.sd = r2; e.rd = 0; end
    else if (op == 7'h63 && f3 == 3'd1) begin e.ctrl = 3'd4; e.a = r1; e.b = r2; e.br = 1; e.rd = 0; end
    else begin e.ill = 1; e.rd = 0; end
    e.rw = wr && (e.rd != 0);
    return e;
  endfunction

  task automatic check_state(input bit flushed);
    check("out_valid", out_valid, m_valid);
    if (m_valid || flushed) begin
      check("reg_write", reg_write, m_ent.rw);
      check("mem_read",  mem_read,  m_ent.mr);
      check("mem_write", mem_write, m_ent.mw);
      check("branch",    branch,    m_ent.br);
      check("illegal",   illegal,   m_ent.ill);
    end
    if (m_valid) begin
      check("alu_a",    alu_a,    m_ent.a);
      check("alu_b",    alu_b,    m_ent.b);
      check("alu_ctrl", alu_ctrl, m_ent.ctrl);
      check("pc_out",   pc_out,   m_ent.pc);
      if (!m_ent.ill) check("rd", rd, m_ent.rd);
      if (m_ent.mw)   check("store_data", store_data, m_ent.sd);
      if (m_ent.br)   check("branch_target", branch_target, m_ent.bt);
    end
  endtask

  // One clock: check in_ready, advance the model by the spec rules, check outputs.
  task automatic step();
    ent_t nxt_e;
    bit   nxt_v;
    bit   fl;
    #1;
    check("in_ready", in_ready, !m_valid || out_ready);
    nxt_e = m_ent;
    nxt_v = m_valid;
    fl    = flush;
    if (flush) begin
      nxt_v = 0;
      nxt_e.rw = 0; nxt_e.mr = 0; nxt_e.mw = 0; nxt_e.br = 0; nxt_e.ill = 0;
    end else if (!m_valid || out_ready) begin
      nxt_v = in_valid;
      if (in_valid) nxt_e = model_decode(instr, pc, rs1_data, rs2_data);
    end
    @(posedge clk);
    #1;
    m_ent   = nxt_e;
    m_valid = nxt_v;
    check_state(fl);
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [6];
    logic [2:0] f3s [6];
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rdf;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
    f3s = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd1, 3'd0};
    k = $urandom_range(0, 5);
    op = (k == 5) ? 7'($urandom) : ops[k];
    f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : f3s[k];
    if (k == 0) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'd4;
        1: f3 = 3'd1;
        default: ;
      endcase
      case ($urandom_range(0, 4))
        0: f7 = 7'h20;
        1: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
    end else begin
      f7 = 7'($urandom);
    end
    rdf = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    return {f7, 10'($urandom), f3, rdf, op};
  endfunction

  initial begin
    m_valid = 0;
    m_ent = model_decode(32'h0, 32'h0, 32'h0, 32'h0);
    m_ent.ill = 0; m_ent.pc = 0; m_ent.bt = 0;

    // reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_ctrl", alu_ctrl, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // add then back-to-back sub
    drive(32'h002081B3, 32'h10, 32'd7, 32'd5);
    step();
    check("add_a", alu_a, 7); check("add_b", alu_b, 5);
    check("add_ctrl", alu_ctrl, 0); check("add_rd", rd, 3); check("add_rw", reg_write, 1);
    drive(32'h402081B3, 32'h14, 32'd7, 32'd5);
    step();
    check("sub_valid", out_valid, 1); check("sub_ctrl", alu_ctrl, 1);

    // lw / sw
    drive(32'hFFC0A283, 32'h18, 32'h100, 32'd0);
    step();
    check("lw_b", alu_b, 32'hFFFFFFFC); check("lw_ctrl", alu_ctrl, 0);
    check("lw_mr", mem_read, 1); check("lw_rd", rd, 5);
    drive(32'h0020A623, 32'h1C, 32'h100, 32'hAB);
    step();
    check("sw_b", alu_b, 12); check("sw_mw", mem_write, 1);
    check("sw_sd", store_data, 32'hAB); check("sw_rw", reg_write, 0);

    // bne
    drive(32'h00209463, 32'h40, 32'd3, 32'd3);
    step();
    check("bne_ctrl", alu_ctrl, 4); check("bne_br", branch, 1);
    check("bne_tgt", branch_target, 32'h48); check("bne_rw", reg_write, 0);

    // backpressure: held entry stays put, new instr not captured
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h50, 32'd99, 32'd1);
    repeat (3) begin
      step();
      check("bp_in_ready", in_ready, 0);
      check("bp_ctrl", alu_ctrl, 4);
      check("bp_pc", pc_out, 32'h40);
    end
    flush = 1'b1;
    step();
    check("fl_valid", out_valid, 0); check("fl_br", branch, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("fl_dropped", out_valid, 0);

    // illegal and add x0
    drive(32'h00000000, 32'h60, 32'd1, 32'd2);
    step();
    check("ill_flag", illegal, 1); check("ill_rw", reg_write, 0);
    check("ill_mr", mem_read, 0); check("ill_mw", mem_write, 0); check("ill_br", branch, 0);
    drive(32'h00208033, 32'h64, 32'd1, 32'd2);
    step();
    check("x0_rw", reg_write, 0); check("x0_ill", illegal, 0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = gen_instr();
      pc        = $urandom & 32'hFFFF_FFFC;
      rs1_data  = $urandom;
      rs2_data  = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    flush = 1'b0;

    // asynchronous reset while an entry is held
    out_ready = 1'b0;
    drive(32'h402081B3, 32'h80, 32'd9, 32'd4);
    step();
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ctrl", alu_ctrl, 0);
    check("arst_rw", reg_write, 0);
    check("arst_a", alu_a, 0);
    check("arst_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
